mp_layer_scheduler: RTL and testbench
=====================================

// Module: mp_layer_scheduler
// PURPOSE
//  Sequences one spiking FC layer over all timesteps. Drives the PE and MP-refresh datapath:
//  - input-synapse index stream;
//  - output channel_num (MP BRAM read address);
//  - one-cycle output_num_switch_pe strobe at each channel boundary.
//  Tracks the timestep and channel counters and reports busy/done to the layer-level controller.
//  A stall input from downstream (neuron FIFO almost-full) freezes sequencing without losing state.
// PARAMETERS
//  OUTPUT_CHANNEL_NUM  256  output neurons per timestep; channel_num counts 0..OUTPUT_CHANNEL_NUM-1
//  INPUT_LEN           64   synapse cycles accumulated per output channel (>=2)
//  TIMESTEPS           8    timesteps per inference (>=1)
//  DRAIN_CYCLES        3    idle cycles after the last strobe, letting the MP pipeline write back
//  CH_W                8    width of channel_num (`CHANNEL_WIDE)
//  IN_W                16   width of syn_addr
// PORTS
//  clk                   in   1     single clock, all logic rising-edge
//  rstn                  in   1     asynchronous active-low reset
//  start                 in   1     1-cycle request to run an inference; ignored unless IDLE
//  abort                 in   1     synchronous abort; returns to IDLE next cycle
//  stall                 in   1     downstream back-pressure; freezes the sequence while 1
//  syn_valid             out  1     syn_addr valid this cycle (PE accumulates)
//  syn_addr              out  IN_W  synapse/input index 0..INPUT_LEN-1
//  channel_num           out  CH_W  current output channel (to PE and MP BRAM addrb)
//  mp_ready              out  1     high for the whole RUN phase; PE/MP start is its rising edge
//  output_num_switch_pe  out  1     1-cycle strobe on the last syn cycle of each channel
//  timestep              out  4     current timestep 0..TIMESTEPS-1
//  timestep_done         out  1     1-cycle pulse, same cycle as the last channel's strobe
//  busy                  out  1     high in RUN and DRAIN
//  done                  out  1     1-cycle pulse when the inference completes
// BEHAVIOUR
//  - All outputs are registered. At reset, every output and counter is 0 and the state is IDLE.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    - IDLE -> RUN: start=1 (and abort=0).
//    - RUN -> DRAIN: strobe for channel OUTPUT_CHANNEL_NUM-1 of timestep TIMESTEPS-1.
//    - DRAIN -> DONE: after DRAIN_CYCLES cycles.
//    - DONE -> IDLE: always, after one cycle; done=1 only in DONE.
//  - Start latency: start sampled at edge N gives first syn_valid=1, syn_addr=0, channel_num=0,
//    timestep=0 in cycle N+1.
//  - RUN with stall=0, every cycle: syn_valid=1; syn_addr increments.
//    - When syn_addr==INPUT_LEN-1: output_num_switch_pe=1 that cycle; next cycle syn_addr=0
//      and channel_num+1.
//    - When channel_num==OUTPUT_CHANNEL_NUM-1: channel_num wraps to 0, timestep_done=1 with
//      the strobe, and timestep+1.
//  - RUN with stall=1: syn_valid=0, output_num_switch_pe=0, timestep_done=0.
//    - All counters hold; mp_ready stays 1.
//    - Resume continues exactly at the held syn_addr, with no skipped or repeated index.
//  - stall is ignored in DRAIN, DONE and IDLE.
//  - mp_ready=1 throughout RUN; it drops to 0 on entry to DRAIN.
//  - busy = RUN or DRAIN.
//  - abort in any state:
//    - next cycle state=IDLE and all outputs=0;
//    - abort has priority over start and stall in the same cycle;
//    - no done pulse is generated.
//  - Counters use exact compares, never free-running overflow; the timestep wraps to 0 only on
//    a new start.
//  - Asynchronous reset mid-RUN: outputs go to 0 immediately; nothing resumes until a new start.
// TESTING  (OUTPUT_CHANNEL_NUM=4, INPUT_LEN=3, TIMESTEPS=2, DRAIN_CYCLES=3 unless noted)
//  1 Basic run: start at cycle 0
//    -> syn_valid cycles 1..24;
//    -> strobes at cycles 3,6,...,24 (8 total);
//    -> timestep_done at 12 and 24;
//    -> done at cycle 28; busy cycles 1..27.
//  2 Stall: stall=1 at cycles 5-7 -> syn_addr holds at 1 (channel 1);
//    strobe for channel 1 at cycle 9; done at cycle 31.
//  3 Abort at cycle 10 (together with stall=1)
//    -> cycle 11 IDLE, all outputs 0, no done;
//    -> a later start restarts at channel 0, timestep 0.
//  4 start pulsed at cycle 5 while busy -> ignored; total strobe count still 8; single done.
//  5 Reset: rstn=0 at cycle 15 -> outputs 0 asynchronously; after release, idle until start.
//  6 Channel wrap, OUTPUT_CHANNEL_NUM=256, INPUT_LEN=2, TIMESTEPS=1
//    -> channel_num 255 -> DRAIN;
//    -> exactly 256 strobes, timestep_done once.

Source files
------------

// File: rtl/mp_layer_scheduler.sv
// rtl/mp_layer_scheduler.sv - timestep/channel/synapse sequencer for one spiking FC layer
module mp_layer_scheduler #(
  parameter int OUTPUT_CHANNEL_NUM = 256,
  parameter int INPUT_LEN          = 64,
  parameter int TIMESTEPS          = 8,
  parameter int DRAIN_CYCLES       = 3,
  parameter int CH_W               = 8,
  parameter int IN_W               = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            stall_i,
  output logic            syn_valid_o,
  output logic [IN_W-1:0] syn_addr_o,
  output logic [CH_W-1:0] channel_num_o,
  output logic            mp_ready_o,
  output logic            output_num_switch_pe_o,
  output logic [3:0]      timestep_o,
  output logic            timestep_done_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [IN_W-1:0] ADDR_LAST  = IN_W'(INPUT_LEN - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(OUTPUT_CHANNEL_NUM - 1);
  localparam logic [3:0]      TS_LAST    = 4'(TIMESTEPS - 1);
  localparam logic [7:0]      DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_e          state_q, state_d;
  logic            syn_valid_q, syn_valid_d;
  logic [IN_W-1:0] syn_addr_q, syn_addr_d;
  logic [CH_W-1:0] channel_q, channel_d;
  logic [3:0]      timestep_q, timestep_d;
  logic            strobe_q, strobe_d;
  logic            ts_done_q, ts_done_d;
  logic            mp_ready_q, mp_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      drain_cnt_q, drain_cnt_d;

  // The cycle on display is the final strobe of the whole inference.
  logic last_strobe;
  assign last_strobe = strobe_q && (channel_q == CH_LAST) && (timestep_q == TS_LAST);

  // State and output registers; every output is driven straight from a flop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      syn_valid_q <= 1'b0;
      syn_addr_q  <= '0;
      channel_q   <= '0;
      timestep_q  <= '0;
      strobe_q    <= 1'b0;
      ts_done_q   <= 1'b0;
      mp_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      syn_valid_q <= syn_valid_d;
      syn_addr_q  <= syn_addr_d;
      channel_q   <= channel_d;
      timestep_q  <= timestep_d;
      strobe_q    <= strobe_d;
      ts_done_q   <= ts_done_d;
      mp_ready_q  <= mp_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state and next-output logic; counters advance from the values currently on display.
  always_comb begin
    state_d     = state_q;
    syn_valid_d = 1'b0;
    syn_addr_d  = syn_addr_q;
    channel_d   = channel_q;
    timestep_d  = timestep_q;
    strobe_d    = 1'b0;
    ts_done_d   = 1'b0;
    mp_ready_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    drain_cnt_d = drain_cnt_q;

    if (abort_i) begin
      state_d     = S_IDLE;
      syn_addr_d  = '0;
      channel_d   = '0;
      timestep_d  = '0;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d     = S_RUN;
            syn_valid_d = 1'b1;
            syn_addr_d  = '0;
            channel_d   = '0;
            timestep_d  = '0;
            strobe_d    = (ADDR_LAST == '0);
            ts_done_d   = (ADDR_LAST == '0) && (CH_LAST == '0);
            mp_ready_d  = 1'b1;
            busy_d      = 1'b1;
          end
        end

        S_RUN: begin
          busy_d = 1'b1;
          if (last_strobe) begin
            // Everything has been issued; a stall here has nothing left to hold.
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end else if (stall_i) begin
            mp_ready_d = 1'b1;
          end else begin
            mp_ready_d  = 1'b1;
            syn_valid_d = 1'b1;
            if (syn_addr_q == ADDR_LAST) begin
              syn_addr_d = '0;
              if (channel_q == CH_LAST) begin
                channel_d  = '0;
                timestep_d = timestep_q + 4'd1;
              end else begin
                channel_d = channel_q + CH_W'(1);
              end
            end else begin
              syn_addr_d = syn_addr_q + IN_W'(1);
            end
            strobe_d  = (syn_addr_d == ADDR_LAST);
            ts_done_d = (syn_addr_d == ADDR_LAST) && (channel_d == CH_LAST);
          end
        end

        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d      = 1'b1;
            drain_cnt_d = drain_cnt_q + 8'd1;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign syn_valid_o            = syn_valid_q;
  assign syn_addr_o             = syn_addr_q;
  assign channel_num_o          = channel_q;
  assign mp_ready_o             = mp_ready_q;
  assign output_num_switch_pe_o = strobe_q;
  assign timestep_o             = timestep_q;
  assign timestep_done_o        = ts_done_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;

endmodule

// File: tb/tb_mp_layer_scheduler.sv
// tb/tb_mp_layer_scheduler.sv - scoreboard bench for mp_layer_scheduler
module tb_mp_layer_scheduler;

  localparam int OCN = 4;
  localparam int ILEN = 3;
  localparam int TS = 2;
  localparam int DRN = 3;
  localparam int OCN_B = 256;
  localparam int ILEN_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic start_a, abort_a, stall_a;
  logic start_b, abort_b, stall_b;

  logic        sv_a, mr_a, sw_a, td_a, busy_a, done_a;
  logic [15:0] addr_a;
  logic [7:0]  ch_a;
  logic [3:0]  ts_a;
  logic        sv_b, mr_b, sw_b, td_b, busy_b, done_b;
  logic [15:0] addr_b;
  logic [7:0]  ch_b;
  logic [3:0]  ts_b;

  mp_layer_scheduler #(
    .OUTPUT_CHANNEL_NUM(OCN), .INPUT_LEN(ILEN), .TIMESTEPS(TS),
    .DRAIN_CYCLES(DRN), .CH_W(8), .IN_W(16)
  ) dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .abort_i(abort_a), .stall_i(stall_a),
    .syn_valid_o(sv_a), .syn_addr_o(addr_a), .channel_num_o(ch_a), .mp_ready_o(mr_a),
    .output_num_switch_pe_o(sw_a), .timestep_o(ts_a), .timestep_done_o(td_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  mp_layer_scheduler #(
    .OUTPUT_CHANNEL_NUM(OCN_B), .INPUT_LEN(ILEN_B), .TIMESTEPS(1),
    .DRAIN_CYCLES(DRN), .CH_W(8), .IN_W(16)
  ) dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_b), .abort_i(abort_b), .stall_i(stall_b),
    .syn_valid_o(sv_b), .syn_addr_o(addr_b), .channel_num_o(ch_b), .mp_ready_o(mr_b),
    .output_num_switch_pe_o(sw_b), .timestep_o(ts_b), .timestep_done_o(td_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  typedef struct packed {
    logic [3:0]  ts;
    logic [7:0]  ch;
    logic [15:0] addr;
    logic        sw;
    logic        tsd;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int done_seen = 0, done_cyc = 0, last_final_cyc = 0;
  int strobes = 0, tsdones = 0, busy_cnt = 0;
  int strobes_b = 0, tsdones_b = 0, done_b_seen = 0, ch_err_b = 0, next_ch_b = 0;
  int tsd_ch_b = -1;
  logic prev_stall = 0, prev_mr = 0, prev_final = 0, prev_abort = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return {30'd0, sv_a, addr_a, ch_a, mr_a, sw_a, ts_a, td_a, busy_a, done_a};
  endfunction

  // Reference model: the full synapse stream of one inference, in issue order.
  task automatic push_run();
    for (int t = 0; t < TS; t++)
      for (int c = 0; c < OCN; c++)
        for (int a = 0; a < ILEN; a++)
          exp_q.push_back('{ts: 4'(t), ch: 8'(c), addr: 16'(a),
                            sw: (a == ILEN - 1), tsd: (a == ILEN - 1) && (c == OCN - 1)});
  endtask

  always @(posedge clk) cyc++;

  // Monitor for the small instance: pops the scoreboard on every valid beat.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 0; prev_mr = 0; prev_final = 0; prev_abort = 0;
    end else begin
      if (sv_a) begin
        if (exp_q.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_beat: got addr %0d ch %0d ts %0d with nothing expected",
                   addr_a, ch_a, ts_a);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("syn_beat", 64'({ts_a, ch_a, addr_a, sw_a, td_a}), 64'(e));
        end
      end else if (sw_a || td_a) begin
        tests++; failed++;
        $display("FAIL strobe_without_valid: got sw %0b tsd %0b expected 0 0", sw_a, td_a);
      end
      if (prev_stall && prev_mr && !prev_final && !prev_abort)
        check("stall_freeze", {sv_a, mr_a}, 2'b01);
      if (sw_a) strobes++;
      if (td_a) tsdones++;
      if (busy_a) busy_cnt++;
      if (sv_a && sw_a && td_a && ts_a == 4'(TS - 1)) last_final_cyc = cyc;
      if (done_a) begin
        done_seen++;
        done_cyc = cyc;
        check("done_latency", 64'(cyc - last_final_cyc), 64'(DRN + 1));
      end
      prev_stall = stall_a;
      prev_mr = mr_a;
      prev_final = sv_a && sw_a && td_a && ts_a == 4'(TS - 1);
      prev_abort = abort_a;
    end
  end

  // Monitor for the wide instance: strobe channels must walk 0..255 in order.
  always @(negedge clk) begin
    if (rstn) begin
      if (sw_b) begin
        if (int'(ch_b) != next_ch_b) ch_err_b++;
        next_ch_b = (next_ch_b + 1) % OCN_B;
        strobes_b++;
      end
      if (td_b) begin
        tsdones_b++;
        tsd_ch_b = int'(ch_b);
      end
      if (done_b) done_b_seen++;
    end
  end

  // One inference on the small instance with optional stall window, random stalls,
  // a stray start, an abort or an asynchronous reset at given relative cycles.
  task automatic run_a(input int st_lo, input int st_hi, input bit rnd, input int start2,
                       input int abort_at, input int rst_at, input int exp_done_rel);
    int c0, d0;
    bit fin;
    fin = 0;
    @(posedge clk); #1;
    start_a = 1; push_run();
    c0 = cyc; d0 = done_seen;
    strobes = 0; tsdones = 0; busy_cnt = 0;
    for (int rel = 1; rel < 400 && !fin; rel++) begin
      @(posedge clk); #1;
      start_a = (rel == start2);
      abort_a = (rel == abort_at);
      stall_a = (rel >= st_lo && rel <= st_hi) || (rnd && ($urandom % 4 == 0));
      if (st_hi == 7 && rel == 7)
        check("stall_hold_addr", {sv_a, ch_a, addr_a}, {1'b0, 8'd1, 16'd1});
      if (rel == abort_at + 1) begin
        exp_q.delete();
        stall_a = 0;
        check("abort_outputs_zero", outs_a(), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        fin = 1;
      end else if (rel == rst_at) begin
        #2 rstn = 0;
        #1 check("async_reset_zero", outs_a(), 64'd0);
        exp_q.delete();
        stall_a = 0; start_a = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (6) @(posedge clk);
        #1 check("idle_after_reset", {sv_a, busy_a, mr_a}, 3'b000);
        check("no_done_after_reset", 64'(done_seen - d0), 64'd0);
        fin = 1;
      end else if (done_seen != d0) begin
        fin = 1;
        stall_a = 0;
        if (exp_done_rel > 0) check("done_cycle", 64'(done_cyc - c0), 64'(exp_done_rel));
        check("strobe_count", 64'(strobes), 64'(OCN * TS));
        check("tsdone_count", 64'(tsdones), 64'(TS));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1 check("single_done", 64'(done_seen - d0), 64'd1);
      end
    end
    start_a = 0; abort_a = 0; stall_a = 0;
    if (!fin) begin
      tests++; failed++;
      $display("FAIL run_timeout: got no completion within 400 cycles expected done");
      exp_q.delete();
    end
  endtask

  initial begin
    rstn = 0;
    start_a = 0; abort_a = 0; stall_a = 0;
    start_b = 0; abort_b = 0; stall_b = 0;
    #12;
    check("reset_outputs_a", outs_a(), 64'd0);
    check("reset_outputs_b", {sv_b, addr_b, ch_b, mr_b, sw_b, ts_b, td_b, busy_b, done_b}, 64'd0);
    @(posedge clk); #1 rstn = 1;
    repeat (2) @(posedge clk);

    // Basic run with exact timing.
    run_a(-1, -1, 0, -1, -1, -1, 28);
    check("busy_cycles", 64'(busy_cnt), 64'd27);
    // Stall window in cycles 5..7.
    run_a(5, 7, 0, -1, -1, -1, 31);
    // Abort together with stall at cycle 10.
    run_a(10, 10, 0, -1, 10, -1, 0);
    // Start pulsed while busy is ignored.
    run_a(-1, -1, 0, 5, -1, -1, 28);
    // Asynchronous reset mid-run.
    run_a(-1, -1, 0, -1, -1, 15, 0);
    // Randomised stalls and stray starts.
    for (int i = 0; i < 6; i++)
      run_a(-1, -1, 1, int'($urandom_range(2, 20)), -1, -1, 0);
    // Random abort point under random stalls, then a clean run to show restart from zero.
    run_a(-1, -1, 1, -1, int'($urandom_range(2, 20)), -1, 0);
    run_a(-1, -1, 1, -1, -1, -1, 0);

    // Wide instance: full channel wrap.
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int k = 0; k < 2000 && done_b_seen == 0; k++) @(posedge clk);
    #1;
    check("wide_done", 64'(done_b_seen), 64'd1);
    check("wide_strobes", 64'(strobes_b), 64'd256);
    check("wide_tsdone", 64'(tsdones_b), 64'd1);
    check("wide_tsdone_ch", 64'(tsd_ch_b), 64'd255);
    check("wide_ch_order", 64'(ch_err_b), 64'd0);
    check("wide_idle", {busy_b, mr_b, sv_b}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
